hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Pipeline hazard and stall controller for the 5-stage RV32I core. It sits beside the per-stage control decode and drives the pipeline-register enables and clears.
- Functions: EX-stage operand forwarding, load-use stall, branch/jump flush, and a data-memory wait FSM with timeout. The wait FSM freezes F..M while a load/store in M is not yet acknowledged.
- Also keeps a saturating stall-cycle performance counter.

Parameters:
- TIMEOUT, 200: max consecutive wait cycles before declaring a memory error (1..2^TO_W-1).
- TO_W, 8: width of the wait counter.
- COUNT_W, 16: width of StallCount.

Ports:
- clk  input  1  core clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- Rs1D  input  5  rs1 of instruction in Decode
- Rs2D  input  5  rs2 of instruction in Decode
- Rs1E  input  5  rs1 of instruction in Execute
- Rs2E  input  5  rs2 of instruction in Execute
- RdE  input  5  rd in Execute
- RdM  input  5  rd in Memory
- RdW  input  5  rd in Writeback
- RegWriteM  input  1  Memory-stage instruction writes rd
- RegWriteW  input  1  Writeback-stage instruction writes rd
- ResultSrcE  input  2  Execute result select; 2'b01 = load
- PCSrcE  input  1  taken branch/jump resolved in Execute
- MemReqM  input  1  Memory-stage instruction is a load/store
- MemReadyM  input  1  data memory completes the access this cycle
- ForwardAE  output  2  SrcA select: 00 reg file, 10 ALUResultM, 01 ResultW
- ForwardBE  output  2  SrcB select, same encoding
- StallF  output  1  hold PC
- StallD  output  1  hold IF/ID register
- StallE  output  1  hold ID/EX register
- StallM  output  1  hold EX/MEM register
- FlushD  output  1  clear IF/ID register to bubble
- FlushE  output  1  clear ID/EX register to bubble
- FlushW  output  1  clear MEM/WB register to bubble
- MemError  output  1  sticky memory timeout flag
- StallCount  output  COUNT_W  saturating count of cycles with StallF=1

Behaviour:
- Reset, asynchronous: state=RUN, wait counter=0, MemError=0, StallCount=0. All other outputs are combinational from state and inputs. They are not forced by reset.
- Forwarding, combinational, operand A (B identical with Rs2E):
  - ForwardAE=10 if RegWriteM & RdM==Rs1E & Rs1E!=0.
  - Otherwise 01 if RegWriteW & RdW==Rs1E & Rs1E!=0.
  - Otherwise 00. M has priority over W.
- lwStall = (ResultSrcE==01) & RdE!=0 & (Rs1D==RdE | Rs2D==RdE).
- memStall:
  - Equals MemReqM & ~MemReadyM in RUN.
  - Equals ~MemReadyM in WAIT.
  - Equals 1 in ERROR.
- Priority, highest first:
  - (1) memStall: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0. A pending branch or load-use stays frozen in place and is handled once the pipeline moves.
  - (2) PCSrcE: FlushD=FlushE=1, StallF=StallD=0. PC must load the target, so this overrides lwStall.
  - (3) lwStall: StallF=StallD=1, FlushE=1.
  - Otherwise all stall/flush outputs are 0.
- StallE, StallM and FlushW are 1 only under memStall.
- FSM:
  - RUN: if MemReqM & ~MemReadyM, go to WAIT and set counter=1. Else stay in RUN.
  - WAIT:
    - MemReadyM=1: go to RUN, counter=0. No stall in this cycle.
    - Else counter==TIMEOUT: go to ERROR.
    - Else counter+1.
  - ERROR: stays until reset. MemError=1, pipeline frozen.
- Zero-wait access (MemReqM & MemReadyM in the same RUN cycle) causes no stall and no state change.
- StallCount increments each cycle StallF=1. It holds at 2^COUNT_W-1 and never wraps.
- Reset asserted mid-WAIT or in ERROR returns to RUN immediately. Counter and flag are cleared.

Test Plan:
- Forwarding: RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5 -> ForwardAE=10. Clear RegWriteM -> ForwardAE=01. Rs1E=0 with both matching -> 00.
- Load-use: ResultSrcE=01, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1, StallE=0. Repeat with RdE=0 -> no stall.
- Branch vs load-use: PCSrcE=1 with lwStall conditions true -> FlushD=FlushE=1, StallF=StallD=0.
- Memory wait: MemReqM=1, MemReadyM=0 for 3 cycles then 1 -> StallF..M=1 and FlushW=1 for exactly 3 cycles, 0 on the ready cycle, StallCount=3. Also hold PCSrcE=1 during the wait -> FlushD=0 until the stall drops.
- Timeout: TIMEOUT=4, MemReqM=1, MemReadyM=0 held -> MemError rises on the 5th edge after the request and stays high. A later MemReadyM=1 has no effect. Async reset mid-cycle -> MemError=0 and stalls release immediately.
- Saturation: COUNT_W=3, hold lwStall 10 cycles -> StallCount reaches 7 and stays at 7.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- hazard and stall controller for the 5-stage RV32I pipeline.
//
// Produces the EX-stage forwarding selects, the pipeline-register stall and
// flush controls, and runs a small data-memory wait FSM (RUN/WAIT/ERROR) that
// freezes F..M while a load/store in M is not yet acknowledged.
//
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   Rs1D/Rs2D              source registers in Decode
//   Rs1E/Rs2E/RdE          source/destination registers in Execute
//   RdM/RdW                destination registers in Memory/Writeback
//   RegWriteM/RegWriteW    M/W instructions write their rd
//   ResultSrcE             Execute result select (2'b01 = load)
//   PCSrcE                 taken branch/jump resolved in Execute
//   MemReqM/MemReadyM      M-stage memory request / completion
//   ForwardAE/ForwardBE    operand selects: 00 regfile, 10 ALUResultM, 01 ResultW
//   StallF..StallM         hold PC / IF-ID / ID-EX / EX-MEM
//   FlushD/FlushE/FlushW   clear IF-ID / ID-EX / MEM-WB to a bubble
//   MemError               sticky memory-timeout flag
//   StallCount             saturating count of cycles with StallF=1
module hazard_ctrl #(
    parameter int TIMEOUT = 200,
    parameter int TO_W    = 8,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [4:0]         Rs1D,
    input  logic [4:0]         Rs2D,
    input  logic [4:0]         Rs1E,
    input  logic [4:0]         Rs2E,
    input  logic [4:0]         RdE,
    input  logic [4:0]         RdM,
    input  logic [4:0]         RdW,
    input  logic               RegWriteM,
    input  logic               RegWriteW,
    input  logic [1:0]         ResultSrcE,
    input  logic               PCSrcE,
    input  logic               MemReqM,
    input  logic               MemReadyM,
    output logic [1:0]         ForwardAE,
    output logic [1:0]         ForwardBE,
    output logic               StallF,
    output logic               StallD,
    output logic               StallE,
    output logic               StallM,
    output logic               FlushD,
    output logic               FlushE,
    output logic               FlushW,
    output logic               MemError,
    output logic [COUNT_W-1:0] StallCount
);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_WAIT = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    state_t             state_reg;
    logic [TO_W-1:0]    wait_cnt_reg;
    logic               mem_error_reg;
    logic [COUNT_W-1:0] stall_count_reg;

    logic lw_stall;
    logic mem_stall;

    // ------------------------------------------------------------------
    // Forwarding: one identical unit per EX operand, M beats W.
    // ------------------------------------------------------------------
    logic [4:0] rs_e [2];
    logic [1:0] fwd  [2];

    assign rs_e[0] = Rs1E;
    assign rs_e[1] = Rs2E;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            always_comb begin
                fwd[gi] = 2'b00;
                if (RegWriteM && (RdM == rs_e[gi]) && (rs_e[gi] != 5'd0))
                    fwd[gi] = 2'b10;
                else if (RegWriteW && (RdW == rs_e[gi]) && (rs_e[gi] != 5'd0))
                    fwd[gi] = 2'b01;
            end
        end
    endgenerate

    assign ForwardAE = fwd[0];
    assign ForwardBE = fwd[1];

    // ------------------------------------------------------------------
    // Stall sources
    // ------------------------------------------------------------------
    assign lw_stall = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                      ((Rs1D == RdE) || (Rs2D == RdE));

    always_comb begin
        mem_stall = 1'b0;
        case (state_reg)
            S_RUN:   mem_stall = MemReqM & ~MemReadyM;
            S_WAIT:  mem_stall = ~MemReadyM;
            S_ERR:   mem_stall = 1'b1;
            default: mem_stall = 1'b1;
        endcase
    end

    // Memory freeze outranks everything: a pending branch or load-use must
    // stay where it is until the pipeline can move again. A taken branch
    // outranks load-use because the PC has to accept the target.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (mem_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (lw_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Memory wait FSM and stall performance counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= S_RUN;
            wait_cnt_reg    <= '0;
            mem_error_reg   <= 1'b0;
            stall_count_reg <= '0;
        end else begin
            case (state_reg)
                S_RUN: begin
                    if (MemReqM && !MemReadyM) begin
                        state_reg    <= S_WAIT;
                        wait_cnt_reg <= TO_W'(1);
                    end
                end
                S_WAIT: begin
                    if (MemReadyM) begin
                        state_reg    <= S_RUN;
                        wait_cnt_reg <= '0;
                    end else if (wait_cnt_reg == TO_W'(TIMEOUT)) begin
                        state_reg     <= S_ERR;
                        mem_error_reg <= 1'b1;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + TO_W'(1);
                    end
                end
                S_ERR: begin
                    // Only reset leaves the error state.
                    mem_error_reg <= 1'b1;
                end
                default: state_reg <= S_RUN;
            endcase

            // Saturate rather than wrap so a long run never reads as short.
            if (StallF && (stall_count_reg != {COUNT_W{1'b1}}))
                stall_count_reg <= stall_count_reg + COUNT_W'(1);
        end
    end

    assign MemError   = mem_error_reg;
    assign StallCount = stall_count_reg;

endmodule
